// File: rtl/lcd_read_controller.sv
// Read-cycle sequencer for an HD44780-style panel: times SETUP / EN_HI / HOLD,
// samples the data bus, and optionally polls the busy flag until it clears.
module lcd_read_controller #(
  parameter int CLK_DIVIDE = 16,
  parameter int POLL_MAX   = 4096
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic [7:0] oData,
  output logic       oDone,
  output logic       oBusy,
  output logic       oTimeout,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int PH_W = (CLK_DIVIDE > 1) ? $clog2(CLK_DIVIDE) : 1;
  localparam int PC_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIVIDE - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EN_HI = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PH_W-1:0]   r_phase;
  logic [PC_W-1:0]   r_poll_cnt;
  logic              r_rs;
  logic              r_poll;
  logic [7:0]        r_data;
  logic              r_done;
  logic              r_busy;
  logic              r_timeout;
  logic              r_rw;
  logic              r_en;
  logic              r_lcd_rs;

  logic              w_last_phase;
  logic              w_accept;
  logic              w_flag_busy;
  logic              w_repoll;
  logic              w_poll_expired;
  logic              w_hold_end;
  logic              w_rs_sel;

  assign w_last_phase   = (r_phase == PH_LAST);
  assign w_accept       = (r_state == IDLE) && iStart;
  // The busy flag is judged from the byte already captured at the end of EN_HI.
  assign w_flag_busy    = r_poll && r_data[7];
  assign w_repoll       = w_flag_busy && (r_poll_cnt < PC_LAST);
  assign w_poll_expired = w_flag_busy && (r_poll_cnt == PC_LAST);
  assign w_hold_end     = (r_state == HOLD) && w_last_phase;
  assign w_rs_sel       = w_accept ? iRS : r_rs;

  // State register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (iStart) w_next = SETUP;
        else        w_next = IDLE;
      end
      SETUP: begin
        if (w_last_phase) w_next = EN_HI;
        else              w_next = SETUP;
      end
      EN_HI: begin
        if (w_last_phase) w_next = HOLD;
        else              w_next = EN_HI;
      end
      HOLD: begin
        if (w_last_phase) w_next = DONE;
        else              w_next = HOLD;
      end
      DONE: begin
        if (w_repoll) w_next = SETUP;
        else          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Phase/poll counters, request latches and the sampled data byte
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_phase    <= '0;
      r_poll_cnt <= '0;
      r_rs       <= 1'b0;
      r_poll     <= 1'b0;
      r_data     <= 8'h00;
      r_timeout  <= 1'b0;
    end else begin
      if ((w_next != r_state) || (r_state == IDLE)) r_phase <= '0;
      else                                          r_phase <= r_phase + PH_W'(1);

      if (w_accept) begin
        r_rs   <= iRS;
        r_poll <= iPoll & ~iRS;
      end

      if (w_accept)                        r_poll_cnt <= '0;
      else if ((r_state == DONE) && w_repoll) r_poll_cnt <= r_poll_cnt + PC_W'(1);

      if ((r_state == EN_HI) && w_last_phase) r_data <= LCD_DATA_IN;

      if (w_accept)                          r_timeout <= 1'b0;
      else if (w_hold_end && w_poll_expired) r_timeout <= 1'b1;
    end
  end

  // Registered panel strobes and status outputs, decoded from the next state
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_rw     <= 1'b0;
      r_en     <= 1'b0;
      r_lcd_rs <= 1'b0;
    end else begin
      r_done   <= w_hold_end && !w_repoll;
      r_busy   <= (w_next != IDLE);
      r_rw     <= (w_next != IDLE);
      r_en     <= (w_next == EN_HI);
      r_lcd_rs <= (w_next != IDLE) && w_rs_sel;
    end
  end

  assign oData    = r_data;
  assign oDone    = r_done;
  assign oBusy    = r_busy;
  assign oTimeout = r_timeout;
  assign LCD_RW   = r_rw;
  assign LCD_EN   = r_en;
  assign LCD_RS   = r_lcd_rs;

endmodule

// File: tb/tb_lcd_read_controller.sv
// Bench for lcd_read_controller: directed vector table, hand sequences for
// reset/back-to-back/CLK_DIVIDE=1, and random reads against a read-count model.
module tb_lcd_read_controller;

  localparam int CD  = 16;
  localparam int PM  = 4;
  localparam int CD1 = 1;
  localparam int PM1 = 2;

  logic       iCLK = 1'b0;
  logic       iRST, iStart, iRS, iPoll;
  logic [7:0] bus;

  logic [7:0] data;
  logic       done, busy, timeout, rw, en, rs;
  logic [7:0] d1_data;
  logic       d1_done, d1_busy, d1_timeout, d1_rw, d1_en, d1_rs;

  lcd_read_controller #(.CLK_DIVIDE(CD), .POLL_MAX(PM)) u_dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
    .oData(data), .oDone(done), .oBusy(busy), .oTimeout(timeout),
    .LCD_DATA_IN(bus), .LCD_RW(rw), .LCD_EN(en), .LCD_RS(rs)
  );

  lcd_read_controller #(.CLK_DIVIDE(CD1), .POLL_MAX(PM1)) u_dut1 (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
    .oData(d1_data), .oDone(d1_done), .oBusy(d1_busy), .oTimeout(d1_timeout),
    .LCD_DATA_IN(bus), .LCD_RW(d1_rw), .LCD_EN(d1_en), .LCD_RS(d1_rs)
  );

  always #5 iCLK = ~iCLK;

  // Panel model: the n-th EN pulse of the current operation returns tab[n].
  logic [7:0] tab [8];
  int         pulses = 0;
  int         base   = 0;
  logic       en_seen = 1'b0;
  int         bidx;

  always @(negedge iCLK) begin
    if (en && !en_seen) pulses <= pulses + 1;
    en_seen <= en;
  end

  always_comb begin
    bidx = pulses - base - 1;
    if (bidx < 0)      bidx = 0;
    else if (bidx > 7) bidx = 7;
    bus = tab[bidx[2:0]];
  end

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_last = 8'h00;

  typedef struct {
    logic       rs;
    logic       poll;
    logic [7:0] b0, b1, b2, b3;
    int         reads;
    logic [7:0] data;
    logic       to;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_tab(input logic [7:0] b0, b1, b2, b3);
    tab[0] = b0;
    tab[1] = b1;
    tab[2] = b2;
    for (int i = 3; i < 8; i++) tab[i] = b3;
  endtask

  // Issues one request at the current negedge and follows it to completion.
  task automatic run_read(input logic r, input logic p, input int exp_reads,
                          input logic [7:0] exp_data, input logic exp_to,
                          input int ignore_at, input string tag);
    int lat;
    int en_cyc;
    bit seen;
    bit bad;
    lat = 1; en_cyc = 0; seen = 1'b0; bad = 1'b0;
    base   = pulses;
    iRS    = r;
    iPoll  = p;
    iStart = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    iStart = 1'b0;
    chk({tag, "_busy_on_accept"}, busy, 1);
    chk({tag, "_data_held"}, data, exp_last);
    chk({tag, "_timeout_cleared"}, timeout, 0);
    while (!seen && lat < 1000) begin
      if (!rw || !busy || (rs !== r)) bad = 1'b1;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (en) en_cyc++;
        iStart = (lat == ignore_at);
        @(negedge iCLK);
        lat++;
      end
    end
    iStart = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, lat, exp_reads * (3 * CD + 1));
    chk({tag, "_en_pulses"}, pulses - base, exp_reads);
    chk({tag, "_en_cycles"}, en_cyc, exp_reads * CD);
    chk({tag, "_rw_rs_busy_during_op"}, bad, 0);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_timeout"}, timeout, exp_to);
    @(negedge iCLK);
    chk({tag, "_done_one_cycle"}, {done, busy, en, rw}, 0);
    chk({tag, "_data_kept"}, {data, timeout}, {exp_data, exp_to});
    exp_last = exp_data;
  endtask

  // Follows the CLK_DIVIDE=1 instance through a single read started concurrently.
  task automatic watch_cd1();
    int l1;
    int en1;
    bit s1;
    l1 = 0; en1 = 0; s1 = 1'b0;
    @(posedge iCLK);
    for (int c = 1; c <= 20 && !s1; c++) begin
      @(negedge iCLK);
      if (d1_en) en1++;
      if (d1_done) begin
        s1 = 1'b1;
        l1 = c;
        chk("cd1_data", d1_data, 8'h3C);
        chk("cd1_busy_in_done", d1_busy, 1);
      end
    end
    chk("cd1_done_seen", s1, 1);
    chk("cd1_latency", l1, 4);
    chk("cd1_en_cycles", en1, 1);
  endtask

  initial begin
    logic       r, p;
    int         k, reads, ign;
    logic [7:0] v, ed;
    logic       et;
    bit         bad;

    vecs[0] = '{1'b1, 1'b0, 8'h54, 8'h54, 8'h54, 8'h54, 1, 8'h54, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h80, 8'h80, 8'h05, 8'h05, 3, 8'h05, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4, 8'hFF, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 1, 8'h80, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h80, 8'h80, 1, 8'h80, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h05, 8'h80, 8'h80, 8'h80, 1, 8'h05, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h7F, 4, 8'h7F, 1'b0};

    fill_tab(8'h00, 8'h00, 8'h00, 8'h00);
    iRST = 1'b1; iStart = 1'b1; iRS = 1'b1; iPoll = 1'b0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("reset_outputs", {data, done, busy, timeout, en, rw, rs}, 0);
    chk("reset_outputs_cd1", {d1_data, d1_done, d1_busy, d1_timeout, d1_en, d1_rw, d1_rs}, 0);
    iRST = 1'b0; iStart = 1'b0;
    @(negedge iCLK);
    chk("idle_after_reset", {busy, rw, en}, 0);

    for (int i = 0; i < 7; i++) begin
      fill_tab(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      run_read(vecs[i].rs, vecs[i].poll, vecs[i].reads, vecs[i].data, vecs[i].to,
               -1, $sformatf("vec%0d", i));
    end

    // Back-to-back reads; the first carries an iStart pulse while busy.
    fill_tab(8'h11, 8'h11, 8'h11, 8'h11);
    run_read(1'b1, 1'b0, 1, 8'h11, 1'b0, 10, "b2b_a");
    fill_tab(8'h22, 8'h22, 8'h22, 8'h22);
    run_read(1'b1, 1'b0, 1, 8'h22, 1'b0, 30, "b2b_b");

    // Reset in the middle of EN_HI, with iStart held alongside it.
    fill_tab(8'h99, 8'h99, 8'h99, 8'h99);
    base = pulses; iRS = 1'b1; iPoll = 1'b0; iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    for (int c = 0; c < 100 && !en; c++) @(negedge iCLK);
    chk("rst_mid_en_reached", en, 1);
    repeat (3) @(negedge iCLK);
    iRST = 1'b1; iStart = 1'b1;
    @(negedge iCLK);
    chk("rst_mid_en_outputs", {data, done, busy, timeout, en, rw, rs}, 0);
    iRST = 1'b0; iStart = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge iCLK);
      if (done || busy || en || (data !== 8'h00)) bad = 1'b1;
    end
    chk("rst_mid_en_quiet", bad, 0);
    exp_last = 8'h00;
    fill_tab(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    run_read(1'b1, 1'b0, 1, 8'h5A, 1'b0, -1, "after_rst");

    // CLK_DIVIDE=1 instance alongside a normal read on the main instance.
    fill_tab(8'h3C, 8'h3C, 8'h3C, 8'h3C);
    fork
      run_read(1'b1, 1'b0, 1, 8'h3C, 1'b0, -1, "cd1_main");
      watch_cd1();
    join

    // Random reads: model counts reads from busy-flag pattern and POLL_MAX.
    for (int n = 0; n < 20; n++) begin
      r = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      k = $urandom_range(0, 5);
      for (int i = 0; i < 8; i++) begin
        v = 8'($urandom);
        v[7] = (i < k);
        tab[i] = v;
      end
      if (p && !r) begin
        reads = (k + 1 < PM) ? k + 1 : PM;
        et    = (k >= PM);
      end else begin
        reads = 1;
        et    = 1'b0;
      end
      ed  = tab[reads - 1];
      ign = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 45) : -1;
      run_read(r, p, reads, ed, et, ign, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_read_controller.md
LCD_READ_CONTROLLER -- requirements
Module: lcd_read_controller

Interface
REQ-001 SHALL have parameter CLK_DIVIDE, default 16: clock cycles per read-cycle phase (setup, EN high, hold).
REQ-002 SHALL have parameter POLL_MAX, default 4096: maximum status reads in one poll operation.
REQ-003 SHALL have one clock, iCLK; reset iRST is synchronous and active-high.
REQ-004 iCLK  in  1  system clock; all state changes on its rising edge.
REQ-005 iRST  in  1  synchronous active-high reset.
REQ-006 iStart  in  1  read request; accepted only in IDLE.
REQ-007 iRS  in  1  register select: 0 = status (busy flag + address counter), 1 = DDRAM/CGRAM data.
REQ-008 iPoll  in  1  1 = repeat status reads until busy flag clears; ignored when iRS=1.
REQ-009 oData  out  8  last byte sampled from the panel.
REQ-010 oDone  out  1  one-cycle completion pulse.
REQ-011 oBusy  out  1  operation in progress.
REQ-012 oTimeout  out  1  poll ended with busy flag still set.
REQ-013 LCD_DATA_IN  in  8  panel data bus, input side of the top-level tristate.
REQ-014 LCD_RW  out  1  1 = read cycle; also the bus-ownership request to the top-level mux.
REQ-015 LCD_EN  out  1  panel enable strobe.
REQ-016 LCD_RS  out  1  panel register select.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, EN_HI, HOLD, DONE.
REQ-018 IDLE with iStart=1 SHALL latch iRS, latch (iPoll & ~iRS), clear oTimeout and the poll counter, and go to SETUP.
REQ-019 iStart outside IDLE SHALL be ignored, with no queuing.
REQ-020 SETUP, EN_HI and HOLD SHALL each last exactly CLK_DIVIDE cycles, timed by a phase counter that resets on every state entry.
REQ-021 LCD_EN SHALL be 1 only in EN_HI.
REQ-022 LCD_RW SHALL be 1 in every state except IDLE.
REQ-023 LCD_RS SHALL equal the latched iRS outside IDLE and 0 in IDLE.
REQ-024 LCD_DATA_IN SHALL be registered into oData on the last EN_HI cycle, the rising edge that ends EN_HI.
REQ-025 After HOLD, DONE SHALL be entered for one cycle.
REQ-026 In DONE, with latched poll=1, oData[7]=1 and poll count < POLL_MAX-1, the FSM SHALL increment the poll count and return to SETUP with no oDone.
REQ-027 In DONE, with latched poll=1, oData[7]=1 and poll count = POLL_MAX-1, the FSM SHALL set oTimeout=1, pulse oDone and go to IDLE.
REQ-028 In all other DONE cases the FSM SHALL pulse oDone for one cycle with oTimeout=0 and go to IDLE.
REQ-029 Latency SHALL be iStart accepted at edge E -> oDone high in cycle E+3*CLK_DIVIDE+1 (49 cycles at default) for one read.
REQ-030 Each extra poll iteration SHALL add 3*CLK_DIVIDE+1 cycles.
REQ-031 oBusy SHALL be 1 in every state except IDLE, including the DONE cycle.
REQ-032 oData and oTimeout SHALL hold their values until the next accepted read: oData changes only on the sample edge, oTimeout clears on accept.
REQ-033 iStart=1 in the cycle after DONE SHALL be accepted (back-to-back reads).
REQ-034 The poll counter SHALL be ceil(log2(POLL_MAX)) bits wide; the phase counter ceil(log2(CLK_DIVIDE)) bits; neither SHALL wrap during an operation.
REQ-035 CLK_DIVIDE=1 SHALL be legal: each phase is one cycle, latency 4.

Reset
REQ-036 iRST=1 at any edge SHALL force IDLE and oData=0, oDone=0, oBusy=0, oTimeout=0, LCD_EN=0, LCD_RW=0, LCD_RS=0, and clear both counters.
REQ-037 Reset mid-operation SHALL drop LCD_EN on that same edge, abort with no oDone, and discard the partial read.
REQ-038 iStart asserted together with iRST SHALL be ignored.

Verification
REQ-039 Single data read: iRS=1, bus=0x54, iStart pulse -> EN high for 16 cycles, oDone at +49, oData=0x54, RS=1, RW=1 throughout.
REQ-040 Status poll clears: iRS=0, iPoll=1, bus=0x80 for 2 reads then 0x05 -> 3 EN pulses, oDone at +147, oData=0x05, oTimeout=0.
REQ-041 Poll timeout (POLL_MAX=4): bus fixed at 0xFF -> exactly 4 EN pulses, oDone with oTimeout=1 and oData=0xFF.
REQ-042 iPoll=1 with iRS=1, bus=0x80 -> single read, oTimeout=0.
REQ-043 Reset mid-EN_HI -> next cycle EN=0, RW=0, oBusy=0, no oDone, oData=0x00; a fresh iStart then completes normally.
REQ-044 Back-to-back reads plus iStart during oBusy -> the ignored request produces no extra EN pulse; a request in the cycle after DONE is accepted.
